// File: rtl/fp_adder_pipe_if.sv
// Operand/result handshake bundle for fp_adder_pipe.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holds valid and data steady until that edge, and ready may depend on the consumer's valid.
interface fp_adder_pipe_if #(
  parameter int MANTISSA   = 11,
  parameter int EXPONENT   = 5,
  parameter int DATA_WIDTH = MANTISSA + EXPONENT
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_A;
  logic [DATA_WIDTH-1:0] in_B;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_sum;
  logic                  out_ovf;
  logic                  out_unf;

  modport master (
    output in_valid, in_A, in_B, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_A, in_B, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_adder_pipe.sv
// Three-stage {mantissa, exponent} adder: compare/align, add, normalise.
// The whole pipe advances together whenever the output register is free or being drained.
module fp_adder_pipe #(
  parameter int MANTISSA   = 11,
  parameter int EXPONENT   = 5,
  parameter int DATA_WIDTH = MANTISSA + EXPONENT
) (
  input  logic             clk,
  input  logic             rst,
  fp_adder_pipe_if.slave   io
);

  localparam int LZW = $clog2(MANTISSA + 1);

  logic adv;

  // Stage 1 combinational: pick the larger-exponent operand and align the other.
  logic [MANTISSA-1:0] ma, mb, m_big, m_small;
  logic [EXPONENT-1:0] ea, eb, e_big, e_small, d;
  logic                a_zero, b_zero, a_big;
  logic [MANTISSA-1:0] s1_big_d, s1_small_d;
  logic [EXPONENT-1:0] s1_emax_d;

  assign ma = io.in_A[DATA_WIDTH-1:EXPONENT];
  assign ea = io.in_A[EXPONENT-1:0];
  assign mb = io.in_B[DATA_WIDTH-1:EXPONENT];
  assign eb = io.in_B[EXPONENT-1:0];

  always_comb begin
    a_zero  = (ma == '0);
    b_zero  = (mb == '0);
    // A zero operand never wins the exponent compare, so its exponent cannot leak into e_max.
    a_big   = b_zero || (!a_zero && (ea >= eb));
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? ma : mb;
    m_small = a_big ? mb : ma;
    d       = e_big - e_small;
    s1_big_d   = m_big;
    s1_emax_d  = e_big;
    s1_small_d = (32'(d) >= 32'(MANTISSA)) ? '0 : (m_small >> d);
  end

  logic                s1_valid_q;
  logic [MANTISSA-1:0] s1_big_q, s1_small_q;
  logic [EXPONENT-1:0] s1_emax_q;

  logic [MANTISSA:0]   s2_sum_d;
  logic                s2_valid_q;
  logic [MANTISSA:0]   s2_sum_q;
  logic [EXPONENT-1:0] s2_emax_q;

  assign s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};

  // Stage 3 combinational: leading-zero count and renormalisation.
  logic [LZW-1:0]        lz;
  logic                  lz_found;
  logic [MANTISSA-1:0]   norm_m;
  logic [DATA_WIDTH-1:0] out_sum_d;
  logic                  out_ovf_d, out_unf_d;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = MANTISSA - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s2_sum_q[i]) lz_found = 1'b1;
        else             lz = lz + LZW'(1);
      end
    end
    norm_m    = s2_sum_q[MANTISSA-1:0] << lz;
    out_sum_d = '0;
    out_ovf_d = 1'b0;
    out_unf_d = 1'b0;
    if (s2_sum_q[MANTISSA]) begin
      if (s2_emax_q == '1) begin
        out_sum_d = '1;
        out_ovf_d = 1'b1;
      end else begin
        out_sum_d = {s2_sum_q[MANTISSA:1], s2_emax_q + EXPONENT'(1)};
      end
    end else if (s2_sum_q != '0) begin
      if (32'(lz) <= 32'(s2_emax_q)) out_sum_d = {norm_m, s2_emax_q - EXPONENT'(lz)};
      else                           out_unf_d = 1'b1;
    end
  end

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_sum_q;
  logic                  out_ovf_q, out_unf_q;

  assign adv          = !out_valid_q || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = out_sum_q;
  assign io.out_ovf   = out_ovf_q;
  assign io.out_unf   = out_unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_big_q    <= '0;
      s1_small_q  <= '0;
      s1_emax_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_emax_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= io.in_valid;
      if (io.in_valid) begin
        s1_big_q   <= s1_big_d;
        s1_small_q <= s1_small_d;
        s1_emax_q  <= s1_emax_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q  <= s2_sum_d;
        s2_emax_q <= s1_emax_q;
      end
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_sum_q <= out_sum_d;
        out_ovf_q <= out_ovf_d;
        out_unf_q <= out_unf_d;
      end
    end
  end

endmodule

// File: doc/fp_adder_pipe.md
Name: fp_adder_pipe

Overview:
- Parametrised, 3-stage pipelined adder for the team's custom floating-point word: {mantissa[MANTISSA-1:0], exponent[EXPONENT-1:0]}, mantissa in the upper bits.
- Successor to the combinational align/add/normalise adder.
- Adds: configurable widths, valid/ready flow control with backpressure, carry-out renormalisation, exponent saturation, underflow flush-to-zero, and status flags.
- Used in the convolution/accumulation datapath.

Parameters:
- MANTISSA, 11, mantissa width in bits (unsigned integer magnitude).
- EXPONENT, 5, exponent width in bits (unsigned).
- DATA_WIDTH, MANTISSA+EXPONENT, derived word width. Not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept the operand pair this cycle.
- in_A  input  DATA_WIDTH  operand A.
- in_B  input  DATA_WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  DATA_WIDTH  result {mantissa, exponent}.
- out_ovf  output  1  result was saturated (exponent overflow).
- out_unf  output  1  result was flushed to zero (normalisation underflow).

Behaviour:
- Value encoding: word = m × 2^e; m and e are unsigned. Zero is any word with m==0; the block always outputs zero as all-zero bits. A result is normalised when m[MANTISSA-1]==1. Inputs may be unnormalised.
- Reset, applied asynchronously: all stage valid bits = 0; out_valid=0, out_sum=0, out_ovf=0, out_unf=0. Reset mid-operation discards all in-flight data. in_ready=1 once reset is released.
- Flow control:
  - adv = !out_valid || out_ready; in_ready = adv.
  - When adv=1 every stage shifts forward one step, and stage-1 valid <= in_valid.
  - When adv=0 all stages hold. Stage contents, including bubbles, do not change.
  - Latency: 3 cycles from an accepted input to out_valid with no stalls. Throughput: 1 result per cycle.
  - out_sum, out_ovf and out_unf are stable while out_valid && !out_ready.
- Stage 1, compare/align:
  - Full unsigned compare of the exponents. The larger exponent is e_max; on a tie, A is treated as the larger.
  - d = e_max - e_min. The smaller-exponent mantissa is logically right-shifted by d; shifted-out bits are truncated.
  - If d >= MANTISSA, the smaller operand contributes 0.
  - A zero operand contributes 0 regardless of its exponent, and its exponent is excluded from e_max. If both operands are zero, the result is zero.
- Stage 2, add: sum = mA' + mB', MANTISSA+1 bits wide.
- Stage 3, normalise:
  - If sum[MANTISSA]==1: m = sum[MANTISSA:1] (truncate LSB) and e = e_max+1. If e_max+1 exceeds 2^EXPONENT-1: out_sum = {all-ones mantissa, all-ones exponent} and out_ovf=1.
  - Else if sum==0: out_sum=0, both flags 0.
  - Else: lz = leading-zero count of sum[MANTISSA-1:0]. If lz <= e_max: m = sum<<lz and e = e_max-lz. If lz > e_max: out_sum=0 and out_unf=1 (no denormals).
  - Flags are per-result and cleared on every non-flagged result.
- Rounding: truncation only. No sign handling; subtraction is out of scope.

Test Plan (MANTISSA=11, EXPONENT=5, words written as m,e):
- A=0x400,3 + B=0x400,3 -> out 0x400,4 with flags 0, exactly 3 cycles after acceptance.
- A=0x600,5 + B=0x400,4 -> B aligned to 0x200; sum 0x800 carries -> out 0x400,6. Swap A and B -> identical result.
- A=0x7FF,31 + B=0x7FF,31 -> out 0x7FF,31, out_ovf=1. Next pair 0x400,1 + 0,0 -> out 0x400,1, out_ovf=0.
- A=0x400,20 + B=0x7FF,9 (d=11) -> out 0x400,20. A=0x001,20 + B=0,0 -> out 0x400,10. A=0x001,5 + B=0,0 -> out 0,0, out_unf=1.
- Back-to-back stream of 8 pairs with out_ready toggled randomly and held low for 4 cycles -> in_ready tracks adv; no result lost or duplicated; outputs stable while stalled; results in order.
- Assert rst for 1 cycle with 3 results in flight -> out_valid=0 immediately (asynchronous); no stale result appears after rst is released; the next accepted pair produces a correct result 3 cycles later.
